// File: rtl/fpga_pkg.sv
// fpga_pkg: frame geometry, mode encodings, CRC polynomial and FSM states
// shared by the single-wire round-robin bus (fpga) and its CRC step.
package fpga_pkg;
  localparam int NODES      = 16;
  localparam int ADDR_W     = 4;
  localparam int MOD_W      = 2;
  localparam int DATA_W     = 64;
  localparam int CRC_W      = 4;
  localparam int FRAME_LEN  = 1 + 2 * ADDR_W + MOD_W + DATA_W + CRC_W;
  localparam int DATA_FIRST = 1 + 2 * ADDR_W + MOD_W;
  localparam int DATA_LAST  = DATA_FIRST + DATA_W - 1;
  localparam logic [MOD_W-1:0] MOD_IDLE  = 2'd0;
  localparam logic [MOD_W-1:0] MOD_UNI   = 2'd1;
  localparam logic [MOD_W-1:0] MOD_BCAST = 2'd2;
  localparam logic [MOD_W-1:0] MOD_RSVD  = 2'd3;
  localparam logic [CRC_W-1:0] CRC_POLY  = 4'h3;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] dst,
    input logic [MOD_W-1:0]  m,
    input logic [DATA_W-1:0] d,
    input logic [CRC_W-1:0]  c
  );
    return {1'b0, src, dst, m, d, c};
  endfunction
endpackage

// File: rtl/fpga_crc4.sv
// fpga_crc4: one serial CRC-4 step (x^4+x+1, MSB first); only built when
// FPGA_CRC_CHECK_EN is defined, since nothing else needs it.
`ifdef FPGA_CRC_CHECK_EN
module fpga_crc4
  import fpga_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);
  assign o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ ((i_crc[CRC_W-1] ^ i_bit) ? CRC_POLY : '0);
endmodule
`endif

// File: rtl/fpga.sv
// fpga: 16-node round-robin serial frame bus with a single receiver.
// FPGA_CRC_CHECK_EN compiles in the receive CRC-4 check driving rxCrcErr.
module fpga
  import fpga_pkg::*;
#(
  parameter int IDLE_GAP = 1
)(
  input  logic              clock,
  input  logic              reset,
  input  logic [CRC_W-1:0]  CRC1, CRC2, CRC3, CRC4,
  input  logic [CRC_W-1:0]  CRC5, CRC6, CRC7, CRC8,
  input  logic [CRC_W-1:0]  CRC9, CRC10, CRC11, CRC12,
  input  logic [CRC_W-1:0]  CRC13, CRC14, CRC15, CRC16,
  input  logic [DATA_W-1:0] Data1, Data2, Data3, Data4,
  input  logic [DATA_W-1:0] Data5, Data6, Data7, Data8,
  input  logic [DATA_W-1:0] Data9, Data10, Data11, Data12,
  input  logic [DATA_W-1:0] Data13, Data14, Data15, Data16,
  input  logic [ADDR_W-1:0] receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
  input  logic [ADDR_W-1:0] receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
  input  logic [ADDR_W-1:0] receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
  input  logic [ADDR_W-1:0] receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
  input  logic [MOD_W-1:0]  mod1, mod2, mod3, mod4,
  input  logic [MOD_W-1:0]  mod5, mod6, mod7, mod8,
  input  logic [MOD_W-1:0]  mod9, mod10, mod11, mod12,
  input  logic [MOD_W-1:0]  mod13, mod14, mod15, mod16,
  inout  wire               bus,
  output logic              rxValid,
  output logic [ADDR_W-1:0] rxSrc,
  output logic [ADDR_W-1:0] rxDst,
  output logic              rxBcast,
  output logic [DATA_W-1:0] rxData,
  output logic              rxCrcErr
);
  logic [NODES*CRC_W-1:0]  w_crc_all;
  logic [NODES*DATA_W-1:0] w_data_all;
  logic [NODES*ADDR_W-1:0] w_dst_all;
  logic [NODES*MOD_W-1:0]  w_mod_all;
  logic [NODES-1:0]        w_req;
  logic [ADDR_W-1:0]       w_gnt;
  logic                    w_any;
  logic [MOD_W-1:0]        w_gnt_mod;
  logic [ADDR_W-1:0]       w_gnt_dst;
  logic [DATA_W-1:0]       w_gnt_data;
  logic [CRC_W-1:0]        w_gnt_crc;
  logic                    w_bus_en;
  logic                    w_last_bit;
  logic                    w_gap_end;
  logic                    w_start;
  logic                    w_accept;
  state_t                  r_state;
  logic [6:0]              r_cnt;
  logic                    r_arm;
  logic [ADDR_W-1:0]       r_ptr;
  logic [FRAME_LEN-1:0]    r_sh;
  logic [ADDR_W-1:0]       r_src;
  logic [ADDR_W-1:0]       r_dst;
  logic [MOD_W-1:0]        r_mod;
  logic [DATA_W-1:0]       r_data;

  assign w_crc_all  = {CRC16, CRC15, CRC14, CRC13, CRC12, CRC11, CRC10, CRC9,
                       CRC8, CRC7, CRC6, CRC5, CRC4, CRC3, CRC2, CRC1};
  assign w_data_all = {Data16, Data15, Data14, Data13, Data12, Data11, Data10, Data9,
                       Data8, Data7, Data6, Data5, Data4, Data3, Data2, Data1};
  assign w_dst_all  = {receiverAddr16, receiverAddr15, receiverAddr14, receiverAddr13,
                       receiverAddr12, receiverAddr11, receiverAddr10, receiverAddr9,
                       receiverAddr8, receiverAddr7, receiverAddr6, receiverAddr5,
                       receiverAddr4, receiverAddr3, receiverAddr2, receiverAddr1};
  assign w_mod_all  = {mod16, mod15, mod14, mod13, mod12, mod11, mod10, mod9,
                       mod8, mod7, mod6, mod5, mod4, mod3, mod2, mod1};

  for (genvar k = 0; k < NODES; k++) begin : g_req
    assign w_req[k] = (w_mod_all[k*MOD_W +: MOD_W] != MOD_IDLE) &&
                      (w_mod_all[k*MOD_W +: MOD_W] != MOD_RSVD);
  end

  // Scan from the pointer downwards in priority so the nearest requester wins.
  always_comb begin
    w_gnt = r_ptr;
    w_any = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (w_req[r_ptr + ADDR_W'(i)]) begin
        w_gnt = r_ptr + ADDR_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_gnt_mod  = w_mod_all[w_gnt*MOD_W +: MOD_W];
  assign w_gnt_dst  = w_dst_all[w_gnt*ADDR_W +: ADDR_W];
  assign w_gnt_data = w_data_all[w_gnt*DATA_W +: DATA_W];
  assign w_gnt_crc  = w_crc_all[w_gnt*CRC_W +: CRC_W];

  assign w_bus_en   = r_state == ST_SEND;
  assign bus        = w_bus_en ? r_sh[FRAME_LEN-1] : 1'bz;
  assign w_last_bit = w_bus_en && r_cnt == 7'(FRAME_LEN - 1);
  assign w_gap_end  = r_state == ST_DONE && r_cnt == 7'(IDLE_GAP - 1);
  // A pending request at the end of the gap starts the next frame directly.
  assign w_start    = w_any && r_arm && (r_state == ST_IDLE || w_gap_end);
  assign w_accept   = !(r_mod == MOD_UNI && r_dst == r_src);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_arm   <= 1'b0;
      r_ptr   <= '0;
      r_sh    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_mod   <= MOD_IDLE;
      r_data  <= '0;
    end else begin
      r_arm <= 1'b1;
      if (w_start) begin
        r_state <= ST_SEND;
        r_cnt   <= '0;
        r_ptr   <= w_gnt + 1'b1;
        r_src   <= w_gnt;
        r_dst   <= w_gnt_dst;
        r_mod   <= w_gnt_mod;
        r_data  <= w_gnt_data;
        r_sh    <= build_frame(w_gnt, w_gnt_dst, w_gnt_mod, w_gnt_data, w_gnt_crc);
      end else if (w_bus_en) begin
        r_sh    <= r_sh << 1;
        r_cnt   <= w_last_bit ? '0 : r_cnt + 1'b1;
        r_state <= w_last_bit ? ST_DONE : ST_SEND;
      end else if (w_gap_end) begin
        r_state <= ST_IDLE;
      end else if (r_state == ST_DONE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxValid <= 1'b0;
      rxSrc   <= '0;
      rxDst   <= '0;
      rxBcast <= 1'b0;
      rxData  <= '0;
    end else begin
      rxValid <= w_last_bit && w_accept;
      if (w_last_bit && w_accept) begin
        rxSrc   <= r_src;
        rxDst   <= r_dst;
        rxBcast <= r_mod == MOD_BCAST;
        rxData  <= r_data;
      end
    end
  end

`ifdef FPGA_CRC_CHECK_EN
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] r_crcf;
  logic [CRC_W-1:0] w_crc_next;
  logic             w_in_data;

  assign w_in_data = w_bus_en && r_cnt >= 7'(DATA_FIRST) && r_cnt <= 7'(DATA_LAST);

  fpga_crc4 u_crc4 (
    .i_crc (r_crc),
    .i_bit (bus),
    .o_crc (w_crc_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_crc    <= '0;
      r_crcf   <= '0;
      rxCrcErr <= 1'b0;
    end else begin
      if (w_start) begin
        r_crc  <= '0;
        r_crcf <= w_gnt_crc;
      end else if (w_in_data) begin
        r_crc <= w_crc_next;
      end
      if (w_last_bit && w_accept) rxCrcErr <= r_crc != r_crcf;
    end
  end
`else
  assign rxCrcErr = 1'b0;
`endif
endmodule

// File: tb/tb_fpga.sv
// tb_fpga: randomized scoreboard bench for the fpga serial frame bus.
module tb_fpga;
  localparam int G = 1;

  typedef struct {
    logic [78:0] frame;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic        bcast;
    logic [63:0] data;
    logic        err;
    int          spacing;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  crc_in  [16];
  logic [3:0]  dst_in  [16];
  logic [63:0] data_in [16];
  logic [1:0]  mod_in  [16];
  wire         bus;
  logic        rxValid, rxBcast, rxCrcErr;
  logic [3:0]  rxSrc, rxDst;
  logic [63:0] rxData;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   en_cnt = 0;

  fpga #(.IDLE_GAP(G)) dut (
    .clock(clock), .reset(reset),
    .CRC1(crc_in[0]), .CRC2(crc_in[1]), .CRC3(crc_in[2]), .CRC4(crc_in[3]),
    .CRC5(crc_in[4]), .CRC6(crc_in[5]), .CRC7(crc_in[6]), .CRC8(crc_in[7]),
    .CRC9(crc_in[8]), .CRC10(crc_in[9]), .CRC11(crc_in[10]), .CRC12(crc_in[11]),
    .CRC13(crc_in[12]), .CRC14(crc_in[13]), .CRC15(crc_in[14]), .CRC16(crc_in[15]),
    .Data1(data_in[0]), .Data2(data_in[1]), .Data3(data_in[2]), .Data4(data_in[3]),
    .Data5(data_in[4]), .Data6(data_in[5]), .Data7(data_in[6]), .Data8(data_in[7]),
    .Data9(data_in[8]), .Data10(data_in[9]), .Data11(data_in[10]), .Data12(data_in[11]),
    .Data13(data_in[12]), .Data14(data_in[13]), .Data15(data_in[14]), .Data16(data_in[15]),
    .receiverAddr1(dst_in[0]), .receiverAddr2(dst_in[1]), .receiverAddr3(dst_in[2]),
    .receiverAddr4(dst_in[3]), .receiverAddr5(dst_in[4]), .receiverAddr6(dst_in[5]),
    .receiverAddr7(dst_in[6]), .receiverAddr8(dst_in[7]), .receiverAddr9(dst_in[8]),
    .receiverAddr10(dst_in[9]), .receiverAddr11(dst_in[10]), .receiverAddr12(dst_in[11]),
    .receiverAddr13(dst_in[12]), .receiverAddr14(dst_in[13]), .receiverAddr15(dst_in[14]),
    .receiverAddr16(dst_in[15]),
    .mod1(mod_in[0]), .mod2(mod_in[1]), .mod3(mod_in[2]), .mod4(mod_in[3]),
    .mod5(mod_in[4]), .mod6(mod_in[5]), .mod7(mod_in[6]), .mod8(mod_in[7]),
    .mod9(mod_in[8]), .mod10(mod_in[9]), .mod11(mod_in[10]), .mod12(mod_in[11]),
    .mod13(mod_in[12]), .mod14(mod_in[13]), .mod15(mod_in[14]), .mod16(mod_in[15]),
    .bus(bus),
    .rxValid(rxValid), .rxSrc(rxSrc), .rxDst(rxDst),
    .rxBcast(rxBcast), .rxData(rxData), .rxCrcErr(rxCrcErr)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [79:0] act, logic [79:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Remainder of data(x)*x^4 divided by x^4+x+1, by long division.
  function automatic logic [3:0] model_crc(logic [63:0] d);
    logic [67:0] v;
    v = {d, 4'b0};
    for (int i = 67; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'h13;
    return v[3:0];
  endfunction

  task automatic push(int k, logic [1:0] m, logic [3:0] d, logic [63:0] data,
                      logic [3:0] c, int sp);
    exp_t e;
    if (m == 2'd1 && d == 4'(k)) return;
    e.frame = {1'b0, 4'(k), d, m, data, c};
    e.src = 4'(k);
    e.dst = d;
    e.bcast = m == 2'd2;
    e.data = data;
`ifdef FPGA_CRC_CHECK_EN
    e.err = c != model_crc(data);
`else
    e.err = 1'b0;
`endif
    e.spacing = sp;
    sb.push_back(e);
  endtask

  task automatic set_node(int k, logic [1:0] m, logic [3:0] d, logic [63:0] data,
                          logic [3:0] c);
    crc_in[k] = c;
    dst_in[k] = d;
    data_in[k] = data;
    mod_in[k] = m;
  endtask

  // Called at a negedge with the bus idle; drops the request once granted.
  task automatic one_frame(int k, logic [1:0] m, logic [3:0] d, logic [63:0] data,
                           logic [3:0] c);
    set_node(k, m, d, data, c);
    push(k, m, d, data, c, 0);
    @(posedge clock);
    #1 mod_in[k] = 2'd0;
    repeat (80 + G) @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    logic [78:0] hist;
    int last_v;
    hist = '0;
    last_v = 0;
    forever begin
      @(negedge clock);
      if (reset) hist = '0;
      else begin
        if (rxValid) begin
          if (sb.size() == 0) chk("unexpected_rxValid", 1, 0);
          else begin
            e = sb.pop_front();
            chk("frame_bits", hist, e.frame);
            chk("rxSrc", rxSrc, e.src);
            chk("rxDst", rxDst, e.dst);
            chk("rxBcast", rxBcast, e.bcast);
            chk("rxData", rxData, e.data);
            chk("rxCrcErr", rxCrcErr, e.err);
            if (e.spacing > 0) chk("spacing", cyc - last_v, e.spacing);
          end
          last_v = cyc;
        end
        hist = {hist[77:0], bus};
      end
      if (dut.w_bus_en) en_cnt++;
      cyc++;
    end
  end

  initial begin
    int base;
    logic [63:0] da, db;
    for (int i = 0; i < 16; i++) set_node(i, 2'd0, 4'd0, 64'd0, 4'd0);
    repeat (3) @(negedge clock);
    chk("rst_valid", rxValid, 0);
    chk("rst_src", rxSrc, 0);
    chk("rst_dst", rxDst, 0);
    chk("rst_data", rxData, 0);
    chk("rst_bcast", rxBcast, 0);
    chk("rst_crcerr", rxCrcErr, 0);
    chk("rst_bus_z", dut.w_bus_en, 0);

    set_node(0, 2'd1, 4'd1, 64'd1, 4'd1);
    push(0, 2'd1, 4'd1, 64'd1, 4'd1, 0);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("no_start_edge1", dut.w_bus_en, 0);
    @(posedge clock);
    #1 chk("start_edge2", dut.w_bus_en, 1);
    mod_in[0] = 2'd0;
    repeat (80 + G) @(negedge clock);
    chk("hold_valid", rxValid, 0);
    chk("hold_data", rxData, 1);

    one_frame(0, 2'd1, 4'd1, 64'd1, 4'd3);
    one_frame(0, 2'd1, 4'd1, 64'd0, 4'd0);
    da = {$urandom, $urandom};
    one_frame(4, 2'd2, 4'hA, da, model_crc(da));

    for (int m = 0; m < 2; m++) begin
      base = en_cnt;
      mod_in[2] = m == 0 ? 2'd3 : 2'd0;
      repeat (200) @(negedge clock);
      chk(m == 0 ? "mod3_bus_idle" : "mod0_bus_idle", en_cnt - base, 0);
      mod_in[2] = 2'd0;
    end

    base = en_cnt;
    one_frame(6, 2'd1, 4'd6, 64'h1234, 4'd0);
    chk("self_addr_on_bus", en_cnt - base, 79);

    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    set_node(0, 2'd1, 4'd5, da, model_crc(da));
    set_node(1, 2'd1, 4'd9, db, 4'($urandom));
    push(0, 2'd1, 4'd5, da, crc_in[0], 0);
    push(1, 2'd1, 4'd9, db, crc_in[1], 79 + G);
    push(0, 2'd1, 4'd5, da, crc_in[0], 79 + G);
    push(1, 2'd1, 4'd9, db, crc_in[1], 79 + G);
    @(posedge clock);
    #1;
    repeat (3 * (79 + G)) @(posedge clock);
    #1 mod_in[0] = 2'd0;
    mod_in[1] = 2'd0;
    repeat (80 + G) @(negedge clock);

    da = {$urandom, $urandom} | 64'd1;
    db = {$urandom, $urandom};
    set_node(0, 2'd1, 4'd3, da, model_crc(da));
    set_node(2, 2'd2, 4'd0, db, model_crc(db));
    push(2, 2'd2, 4'd0, db, crc_in[2], 0);
    push(0, 2'd1, 4'd3, da, crc_in[0], 79 + G);
    @(posedge clock);
    #1;
    repeat (79 + G) @(posedge clock);
    #1 mod_in[0] = 2'd0;
    mod_in[2] = 2'd0;
    repeat (80 + G) @(negedge clock);

    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    set_node(0, 2'd1, 4'd7, da, model_crc(da));
    set_node(5, 2'd1, 4'd2, db, model_crc(db));
    @(posedge clock);
    #1;
    repeat (30) @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("midrst_bus_z", dut.w_bus_en, 0);
    chk("midrst_valid", rxValid, 0);
    chk("midrst_data", rxData, 0);
    chk("midrst_src", rxSrc, 0);
    push(0, 2'd1, 4'd7, da, crc_in[0], 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("midrst_no_start_edge1", dut.w_bus_en, 0);
    @(posedge clock);
    #1 chk("midrst_start_edge2", dut.w_bus_en, 1);
    mod_in[0] = 2'd0;
    mod_in[5] = 2'd0;
    repeat (80 + G) @(negedge clock);

    for (int n = 0; n < 16; n++) begin
      int k;
      logic [1:0] m;
      logic [3:0] d, c;
      k = int'($urandom_range(0, 15));
      m = 2'($urandom_range(1, 2));
      d = 4'($urandom_range(0, 15));
      da = {$urandom, $urandom};
      c = $urandom_range(0, 1) == 1 ? model_crc(da) : 4'($urandom);
      one_frame(k, m, d, da, c);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fpga.md
FPGA -- requirements
Module: fpga

Interface
REQ-001 SHALL provide parameter IDLE_GAP, default 1, the number of bus-idle (z) cycles between frames (range 1..4).
REQ-002 SHALL provide clock input, 1 bit; single clock; all state updates on its rising edge.
REQ-003 SHALL provide reset input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL provide CRC1..CRC16 inputs, 4 bits each; sender-supplied CRC-4 of node k's Data.
REQ-005 SHALL provide Data1..Data16 inputs, 64 bits each; payload of node k.
REQ-006 SHALL provide receiverAddr1..receiverAddr16 inputs, 4 bits each; destination address of node k's frame.
REQ-007 SHALL provide mod1..mod16 inputs, 2 bits each; node k mode: 0 idle, 1 unicast, 2 broadcast, 3 reserved (treated as idle).
REQ-008 SHALL provide bus inout, 1 bit; serial frame line, driven only while a frame bit is sent, high-impedance otherwise.
REQ-009 SHALL provide rxValid output, 1 bit; one-cycle pulse when a frame completes.
REQ-010 SHALL provide rxSrc output (4 bits, sender address) and rxDst output (4 bits, frame destination address).
REQ-011 SHALL provide rxBcast output (1 bit, frame was broadcast), rxData output (64 bits, payload) and rxCrcErr output (1 bit, CRC mismatch).

Function
REQ-012 Node k SHALL have fixed address k-1 (node1 = 0 ... node16 = 15).
REQ-013 Node k SHALL request the bus whenever mod k is 1 or 2, level-sensitive, and SHALL re-request after each frame while the mode stays nonzero.
REQ-014 Arbitration SHALL be round-robin, starting after the last granted node; after reset node1 has top priority.
REQ-015 States SHALL be IDLE, SEND and DONE: IDLE moves to SEND on the edge with any request; SEND lasts 79 cycles; DONE lasts IDLE_GAP cycles and then returns to IDLE.
REQ-016 The granted node's addr, receiverAddr, mod, Data and CRC SHALL be captured at grant; input changes during a frame SHALL be ignored.
REQ-017 Frame format, 79 bits, MSB first: start bit 0, src[3:0], dst[3:0], mod[1:0], data[63:0], crc[3:0].
REQ-018 bus SHALL be z in IDLE and DONE and after reset.
REQ-019 rxValid SHALL pulse in the first DONE cycle, with rxSrc, rxDst, rxBcast and rxData valid then and held until the next pulse.
REQ-020 A unicast frame whose dst equals src SHALL still complete on the bus, but rxValid SHALL be suppressed.
REQ-021 CRC-4 SHALL use polynomial x^4+x+1 with init 0, processed serially over the 64 data bits MSB first with no final XOR.
REQ-022 rxCrcErr SHALL be set with rxValid when the computed CRC differs from the received crc field.

Reset
REQ-023 Reset SHALL force, immediately including mid-frame: state IDLE, bus z, rxValid/rxCrcErr/rxBcast 0, rxSrc/rxDst 0, rxData 0, arbiter pointer to node1.
REQ-024 After reset deassertion, the first frame SHALL start no earlier than the second rising clock edge.

Configuration
REQ-025 Macro FPGA_CRC_CHECK_EN defined SHALL compile in the receive CRC computation and rxCrcErr per REQ-022.
REQ-026 Without FPGA_CRC_CHECK_EN, rxCrcErr SHALL be tied 0, all frames SHALL be accepted, and the crc field SHALL still be transmitted.

Structure
REQ-027 Package fpga_pkg SHALL hold the frame length (79), field widths, mode encodings, CRC polynomial (4'h3) and the state enum.
REQ-028 The serial CRC-4 step SHALL be the single sub-module fpga_crc4.

Verification
REQ-029 Node1 mod=1, Data=1, CRC=1, receiverAddr=1, others idle -> after 80 cycles rxValid=1, rxSrc=0, rxDst=1, rxData=1, rxCrcErr=1 (correct CRC is 3).
REQ-030 Same with CRC1=3 -> rxCrcErr=0; Data=0, CRC=0 -> rxCrcErr=0.
REQ-031 Nodes 1 and 2 both mod=1 -> frames alternate src 0, 1, 0, 1; each rxValid spaced 79+IDLE_GAP cycles.
REQ-032 Node5 mod=2 -> rxBcast=1, rxSrc=4; bus bit sequence begins 0,0,1,0,0.
REQ-033 Reset asserted at bit 30 of a frame -> bus z in the same cycle, no rxValid; after release, the frame restarts from node1 priority.
REQ-034 Node3 with mod 3 or 0 -> bus stays z and rxValid never asserts.
